// File: rtl/jtkicker_sdram_resp.sv
// jtkicker_sdram_resp: stand-in responder for the game-top SDRAM interface.
// Serves ROM-slot burst reads and download byte writes from an internal
// 16-bit word memory so a core can run without the board SDRAM.
//
// Handshakes:
//   Read : sdram_req is sampled in IDLE while downloading=0. sdram_ack pulses
//          for one cycle in the next cycle; the request may drop at any time
//          after that and the burst still completes. data_dst marks each of
//          the BURST words on data_read; data_rdy marks the last one.
//   Write: prog_we is sampled in IDLE while downloading=1 and should be held
//          until sdram_ack, which pulses in the cycle the write is committed.
//          The following GUARD cycle ignores prog_we so a requester that
//          drops it one cycle late does not issue a second write.
`timescale 1ns/1ps

module jtkicker_sdram_resp #(
    parameter int AW    = 16,
    parameter int LAT   = 3,
    parameter int BURST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    output logic        sdram_ack,
    output logic        data_dst,
    output logic        data_rdy,
    output logic [15:0] data_read,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    input  logic        prog_we,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RWAIT = 3'd1,
        ST_RDATA = 3'd2,
        ST_WWAIT = 3'd3,
        ST_GUARD = 3'd4
    } state_t;

    localparam logic [3:0] LAT_CNT   = 4'(LAT);
    localparam logic [1:0] LAST_BEAT = 2'(BURST - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr;
    logic [1:0]    beat;
    logic [7:0]    wdata;
    logic [1:0]    wmask;
    logic          commit;

    logic [15:0]   mem [0:(2**AW)-1];

    // Only the low AW address bits select a word; the rest are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{sdram_addr, prog_addr};

    // The write lands on the same edge that raises sdram_ack.
    assign commit = (state == ST_WWAIT) && (cnt == 4'd1);
    assign busy   = (state != ST_IDLE);

    // Memory write port: no reset so contents survive rst; rst blocks a commit.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            if (!wmask[0]) mem[addr][7:0]  <= wdata;
            if (!wmask[1]) mem[addr][15:8] <= wdata;
        end
    end

    // Control FSM: arbitration, latency count, burst sequencing, registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            addr      <= '0;
            beat      <= 2'd0;
            wdata     <= 8'd0;
            wmask     <= 2'b11;
            sdram_ack <= 1'b0;
            data_dst  <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= 16'd0;
        end else begin
            sdram_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (prog_we && downloading) begin
                        addr  <= prog_addr[AW-1:0];
                        wdata <= prog_data;
                        wmask <= prog_mask;
                        cnt   <= LAT_CNT;
                        state <= ST_WWAIT;
                    end else if (sdram_req && !downloading) begin
                        addr      <= sdram_addr[AW-1:0];
                        cnt       <= LAT_CNT;
                        sdram_ack <= 1'b1;
                        state     <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    // Last wait cycle: present the first word on the next cycle.
                    if (cnt == 4'd1) begin
                        data_read <= mem[addr];
                        data_dst  <= 1'b1;
                        data_rdy  <= (LAST_BEAT == 2'd0);
                        beat      <= 2'd0;
                        addr      <= addr + AW'(1);
                        state     <= ST_RDATA;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RDATA: begin
                    // beat is the index of the word currently on data_read.
                    if (beat == LAST_BEAT) begin
                        data_dst <= 1'b0;
                        data_rdy <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        data_read <= mem[addr];
                        data_rdy  <= ((beat + 2'd1) == LAST_BEAT);
                        beat      <= beat + 2'd1;
                        addr      <= addr + AW'(1);
                    end
                end
                ST_WWAIT: begin
                    if (cnt == 4'd1) begin
                        sdram_ack <= 1'b1;
                        state     <= ST_GUARD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_GUARD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jtkicker_sdram_resp.md
Name: jtkicker_sdram_resp

Overview:
- Responder end of the game-top SDRAM interface.
- Serves ROM-slot read requests (sdram_req/sdram_addr → sdram_ack, data_dst, data_rdy, data_read) and download write requests (prog_addr/prog_data/prog_mask/prog_we → sdram_ack) from an internal 16-bit word memory.
- Stands in for the SDRAM controller in per-core simulation and small FPGA builds, so cores run without the board SDRAM.

Parameters:
- AW, 16, memory word-address width; depth 2^AW 16-bit words.
- LAT, 3, cycles from sdram_ack to first data_dst (reads) or to write commit (writes); legal 1..15.
- BURST, 2, 16-bit words returned per read; legal 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- downloading  in  1  ROM download in progress
- sdram_req  in  1  read request from ROM slot arbiter
- sdram_addr  in  22  read word address
- sdram_ack  out  1  one-cycle acknowledge (read accepted or write committed)
- data_dst  out  1  high while data_read carries a valid burst word
- data_rdy  out  1  one-cycle pulse with the last burst word
- data_read  out  16  read data
- prog_addr  in  22  write word address
- prog_data  in  8  write byte, replicated on both lanes
- prog_mask  in  2  byte-lane enables, active low; bit0 → [7:0], bit1 → [15:8]
- prog_we  in  1  write request, held until sdram_ack
- busy  out  1  FSM not in IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: sdram_ack=0, data_dst=0, data_rdy=0, data_read=0, busy=0, FSM=IDLE.
  - Memory contents are preserved.
  - Reset mid-operation aborts the transaction and commits no write.
- Addressing: only the low AW bits of sdram_addr/prog_addr are used. The burst address increments modulo 2^AW, so it wraps at the top of memory.
- States: IDLE, RWAIT, RDATA, WWAIT, GUARD.
- IDLE arbitration:
  - If prog_we=1 and downloading=1: latch prog_addr/prog_data/prog_mask, load the latency counter with LAT, go to WWAIT.
  - Else if sdram_req=1 and downloading=0:
    - Assert sdram_ack in the next cycle (one cycle only).
    - Latch sdram_addr.
    - Load the counter with LAT, go to RWAIT.
  - sdram_req while downloading=1 is ignored: no ack.
  - prog_we while downloading=0 is ignored.
- RWAIT: decrement the counter each cycle; at zero go to RDATA.
  - The first data_dst occurs exactly LAT+1 cycles after the cycle sdram_req was sampled.
- RDATA:
  - For BURST consecutive cycles: data_dst=1, data_read=mem[addr+i].
  - data_rdy=1 only on the cycle i=BURST-1.
  - Then go to IDLE. data_read holds its last value afterwards.
  - A new sdram_req may be accepted in the first IDLE cycle (back-to-back).
- WWAIT: count LAT cycles, then commit the write:
  - Low byte is written if prog_mask[0]=0; high byte if prog_mask[1]=0.
  - mask=2'b11 writes nothing but is still acknowledged.
  - sdram_ack pulses in the commit cycle. Go to GUARD.
- GUARD: one cycle; prog_we/sdram_req are ignored, covering the cycle in which the requester drops prog_we. Then IDLE.
- Request-drop rules:
  - sdram_req dropped after acceptance: the read still completes fully.
  - downloading falling during WWAIT: the write still commits.
- busy = (state != IDLE).
- Read-after-write to the same address returns the new data, since the commit precedes the GUARD cycle.

Test Plan:
- Reset, then preload mem[0x10]=0x1234, mem[0x11]=0xABCD. Pulse sdram_req, addr=0x10, LAT=3, BURST=2 → sdram_ack at t+1; data_dst at t+4 (0x1234) and t+5 (0xABCD); data_rdy only at t+5.
- downloading=1, prog_addr=0x20, prog_data=0x5A, mask=2'b10, prog_we held → ack LAT+1 cycles later, mem[0x20][7:0]=0x5A, high byte unchanged. Then mask=2'b01 with data 0xC3 → mem[0x20]=0xC35A.
- sdram_req held high with downloading=1 → no sdram_ack, busy=0. Drop downloading → read accepted next cycle.
- Read at addr=2^AW-1 with BURST=2 → words mem[2^AW-1] then mem[0].
- prog_we held one cycle past ack → GUARD ignores it; a second write occurs only if prog_we is still high in IDLE. Check exactly one commit for a single-pulse ack protocol.
- rst asserted in RWAIT and in WWAIT → outputs 0 next cycle, no data_dst, no memory change. A later read returns the pre-reset contents.
